reservation_station: RTL and testbench

Parametrised out-of-order reservation station between rename/dispatch and the functional units. Holds up to RS_ENTRIES dispatched instructions, tracks source-operand readiness by snooping NUM_WB writeback tag broadcasts, and issues the oldest fully-ready entry to its FU through a valid/ready handshake. It replaces fixed 4-entry, single-wakeup scheduling with configurable depth, configurable wakeup width and flush support.

---
 rtl/reservation_station_pkg.sv | 23 ++
 rtl/reservation_station_rs_select.sv | 24 ++
 rtl/reservation_station.sv | 130 +++++++++++++
 tb/tb_reservation_station.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared sizes and packet/entry types for the reservation station
package reservation_station_pkg;

  localparam int RS_ENTRIES = 4;
  localparam int NUM_PREGS  = 64;
  localparam int NUM_WB     = 2;
  localparam int PW         = $clog2(NUM_PREGS);

  typedef struct packed {
    logic [3:0]    op;
    logic [5:0]    rob_id;
    logic [PW-1:0] dst_preg;
    logic [PW-1:0] src1_preg;
    logic [PW-1:0] src2_preg;
  } disp_packet_t;

  typedef struct packed {
    disp_packet_t pkt;
    logic         src1_rdy;
    logic         src2_rdy;
  } rs_entry_t;

endpackage

// File: rtl/reservation_station_rs_select.sv
// rtl/reservation_station_rs_select.sv - combinational oldest-ready picker over an age matrix
module rs_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [N-1:0][N-1:0] age,
  output logic [N-1:0]        grant,
  output logic                any
);

  // age[j][i] = 1 means entry j was allocated before entry i
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && req[j] && age[j][i]) grant[i] = 1'b0;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - out-of-order reservation station; RS_DISPATCH_BYPASS_EN adds zero-cycle dispatch-to-issue
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_ENTRIES = reservation_station_pkg::RS_ENTRIES,
  parameter int NUM_PREGS  = reservation_station_pkg::NUM_PREGS,
  parameter int NUM_WB     = reservation_station_pkg::NUM_WB
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 disp_valid,
  output logic                                 disp_ready,
  input  disp_packet_t                         disp_pkt,
  input  logic                                 disp_src1_rdy,
  input  logic                                 disp_src2_rdy,
  input  logic [NUM_WB-1:0]                    wb_valid,
  input  logic [NUM_WB*$clog2(NUM_PREGS)-1:0]  wb_preg,
  output logic                                 issue_valid,
  output disp_packet_t                         issue_pkt,
  input  logic                                 issue_ready,
  output logic [$clog2(RS_ENTRIES+1)-1:0]      rs_count
);

  localparam int TW = $clog2(NUM_PREGS);
  localparam int IW = $clog2(RS_ENTRIES);
  localparam int CW = $clog2(RS_ENTRIES+1);

  logic [RS_ENTRIES-1:0]                 valid;
  rs_entry_t                             ent [RS_ENTRIES];
  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] age;
  logic [CW-1:0]                         count;

  logic [RS_ENTRIES-1:0] wake1, wake2, req, grant;
  logic                  disp_w1, disp_w2, new_r1, new_r2;
  logic                  any_rdy, disp_fire, alloc, stored_issue;
  logic [IW-1:0]         alloc_idx;
  disp_packet_t          sel_pkt;

  // Tag match of every broadcast port against stored and incoming sources
  always_comb begin
    disp_w1 = 1'b0;
    disp_w2 = 1'b0;
    wake1   = '0;
    wake2   = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k]) begin
        if (wb_preg[k*TW +: TW] == disp_pkt.src1_preg) disp_w1 = 1'b1;
        if (wb_preg[k*TW +: TW] == disp_pkt.src2_preg) disp_w2 = 1'b1;
        for (int i = 0; i < RS_ENTRIES; i++) begin
          if (wb_preg[k*TW +: TW] == ent[i].pkt.src1_preg) wake1[i] = 1'b1;
          if (wb_preg[k*TW +: TW] == ent[i].pkt.src2_preg) wake2[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = RS_ENTRIES-1; i >= 0; i--) begin
      if (!valid[i]) alloc_idx = IW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      req[i] = valid[i] && ent[i].src1_rdy && ent[i].src2_rdy;
    end
  end

  rs_select #(.N(RS_ENTRIES)) u_select (
    .req   (req),
    .age   (age),
    .grant (grant),
    .any   (any_rdy)
  );

  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (grant[i]) sel_pkt = ent[i].pkt;
    end
  end

  assign disp_ready   = (count < CW'(RS_ENTRIES));
  assign disp_fire    = disp_valid && disp_ready;
  assign new_r1       = disp_src1_rdy || disp_w1;
  assign new_r2       = disp_src2_rdy || disp_w2;
  assign stored_issue = any_rdy && issue_ready;
  assign rs_count     = count;

`ifdef RS_DISPATCH_BYPASS_EN
  logic bypass;
  // Stored ready entries always take priority over the incoming packet
  assign bypass      = !any_rdy && disp_fire && new_r1 && new_r2;
  assign issue_valid = any_rdy || bypass;
  assign issue_pkt   = any_rdy ? sel_pkt : disp_pkt;
  assign alloc       = disp_fire && !(bypass && issue_ready);
`else
  assign issue_valid = any_rdy;
  assign issue_pkt   = sel_pkt;
  assign alloc       = disp_fire;
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (valid[i]) begin
          ent[i].src1_rdy <= ent[i].src1_rdy || wake1[i];
          ent[i].src2_rdy <= ent[i].src2_rdy || wake2[i];
        end
        if (stored_issue && grant[i]) valid[i] <= 1'b0;
      end
      if (alloc) begin
        valid[alloc_idx] <= 1'b1;
        ent[alloc_idx]   <= '{pkt: disp_pkt, src1_rdy: new_r1, src2_rdy: new_r2};
        // Newcomer is younger than everything currently held
        for (int j = 0; j < RS_ENTRIES; j++) begin
          age[j][alloc_idx] <= 1'b1;
        end
        age[alloc_idx] <= '0;
      end
      count <= count + CW'(alloc) - CW'(stored_issue);
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - table-driven directed bench for reservation_station
module tb_reservation_station;
  import reservation_station_pkg::*;

`ifdef RS_DISPATCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic         clk = 1'b0;
  logic         rst, flush, disp_valid, disp_ready, disp_src1_rdy, disp_src2_rdy;
  logic         issue_valid, issue_ready;
  disp_packet_t disp_pkt, issue_pkt;
  logic [1:0]   wb_valid;
  logic [11:0]  wb_preg;
  logic [2:0]   rs_count;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_pkt      (disp_pkt),
    .disp_src1_rdy (disp_src1_rdy),
    .disp_src2_rdy (disp_src2_rdy),
    .wb_valid      (wb_valid),
    .wb_preg       (wb_preg),
    .issue_valid   (issue_valid),
    .issue_pkt     (issue_pkt),
    .issue_ready   (issue_ready),
    .rs_count      (rs_count)
  );

  typedef struct {
    int dv, dst, s1, r1, s2, r2, wbv, wb0, wb1, ir, fl;
    int eiv, edst, ecnt, edr;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input int dv, dst, s1, r1, s2, r2, wbv, wb0, wb1, ir, fl,
                     input int eiv, edst, ecnt, edr);
    vec_t v;
    v = '{dv, dst, s1, r1, s2, r2, wbv, wb0, wb1, ir, fl, eiv, edst, ecnt, edr};
    vecs.push_back(v);
  endtask

  task automatic idle(input int ir, eiv, edst, ecnt, edr);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0, ir, 0, eiv, edst, ecnt, edr);
  endtask

  task automatic drive(input vec_t v);
    disp_valid         = 1'(v.dv);
    disp_pkt.op        = 4'(v.dst);
    disp_pkt.rob_id    = 6'(v.dst);
    disp_pkt.dst_preg  = 6'(v.dst);
    disp_pkt.src1_preg = 6'(v.s1);
    disp_pkt.src2_preg = 6'(v.s2);
    disp_src1_rdy      = 1'(v.r1);
    disp_src2_rdy      = 1'(v.r2);
    wb_valid           = 2'(v.wbv);
    wb_preg            = {6'(v.wb1), 6'(v.wb0)};
    issue_ready        = 1'(v.ir);
    flush              = 1'(v.fl);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input vec_t v, input int idx);
    check("issue_valid", idx, int'(issue_valid), v.eiv);
    if (v.eiv != 0) check("issue_dst", idx, int'(issue_pkt.dst_preg), v.edst);
    check("rs_count", idx, int'(rs_count), v.ecnt);
    check("disp_ready", idx, int'(disp_ready), v.edr);
  endtask

  initial begin
    vec_t v;
    // reset state
    idle(0, 0, 0, 0, 1);
    // in-order issue of four ready dispatches
    add(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, BYP, 1, 0, 1);
    add(1, 2, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 1, 1);
    add(1, 3, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 2, 1, 1);
    add(1, 4, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 3, 1, 1);
    idle(1, 1, 4, 1, 1);
    idle(1, 0, 0, 0, 1);
    // fill with src1=7 pending, full ignores dispatch, port-1 wakeup
    add(1, 11, 7, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    add(1, 12, 7, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(1, 13, 7, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2, 1);
    add(1, 14, 7, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 3, 1);
    add(1, 99, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4, 0);
    add(0, 0, 0, 1, 0, 1, 2, 0, 7, 0, 0, 0, 0, 4, 0);
    idle(1, 1, 11, 4, 0);
    idle(1, 1, 12, 3, 1);
    idle(1, 1, 13, 2, 1);
    idle(1, 1, 14, 1, 1);
    idle(0, 0, 0, 0, 1);
    // same-cycle wakeup captured at dispatch
    add(1, 21, 0, 1, 12, 0, 1, 12, 0, 0, 0, BYP, 21, 0, 1);
    idle(1, 1, 21, 1, 1);
    idle(0, 0, 0, 0, 1);
    // older entry wakes while stalled and overtakes the younger one
    add(1, 31, 40, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 32, 0, 1, 0, 1, 0, 0, 0, 0, 0, BYP, 32, 1, 1);
    add(0, 0, 0, 1, 0, 1, 1, 40, 0, 0, 0, 1, 32, 2, 1);
    idle(0, 1, 31, 2, 1);
    idle(1, 1, 31, 2, 1);
    idle(1, 1, 32, 1, 1);
    idle(0, 0, 0, 0, 1);
    // flush with simultaneous dispatch and issue at three entries
    add(1, 41, 50, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 42, 50, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 43, 0, 1, 0, 1, 0, 0, 0, 0, 0, BYP, 43, 2, 1);
    add(1, 44, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 43, 3, 1);
    add(0, 0, 0, 1, 0, 1, 1, 50, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 1);
    // dispatch into empty station with the FU ready
    add(1, 51, 0, 1, 0, 1, 0, 0, 0, 1, 0, BYP, 51, 0, 1);
    idle(1, 1 - BYP, 51, 1 - BYP, 1);
    idle(0, 0, 0, 0, 1);

    v = vecs[0];
    drive(v);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      check_outputs(vecs[i], i);
    end

    // reset in the middle of operation discards held entries
    @(negedge clk);
    v = vecs[0];
    v.dv = 1; v.dst = 61; v.s1 = 60; v.r1 = 0;
    drive(v);
    @(negedge clk);
    v.dst = 62;
    drive(v);
    @(negedge clk);
    drive(vecs[0]);
    #1;
    check("pre_reset_count", 100, int'(rs_count), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_reset_count", 101, int'(rs_count), 0);
    check("mid_reset_issue_valid", 101, int'(issue_valid), 0);
    check("mid_reset_disp_ready", 101, int'(disp_ready), 1);
    v = vecs[0];
    v.wbv = 1; v.wb0 = 60; v.ir = 0;
    drive(v);
    @(negedge clk);
    drive(vecs[0]);
    #1;
    check("post_reset_wake", 102, int'(issue_valid), 0);
    check("post_reset_count", 102, int'(rs_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
